// File: rtl/fault_recovery_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fault_recovery_ctrl
//  Purpose  : Pipeline fault recovery sequencer. When a qualified fault is seen
//             while idle, it flushes and stalls the pipeline, then issues a
//             one-cycle replay redirect to the faulting PC. If the same
//             instruction faults too many times in a row, it raises a level
//             trap that is held until the handler acknowledges it.
//
//  Ports    : clk            - rising-edge clock
//             rst_n          - asynchronous active-low reset
//             fault_detected - fault flag for the instruction under check
//             instr_valid    - qualifies fault_detected
//             fault_pc       - PC of the instruction under check
//             retire         - instruction committed cleanly (clears retries)
//             trap_ack       - trap handler acknowledge
//             stall          - freeze fetch/decode (FLUSH and TRAP)
//             flush          - kill in-flight pipeline contents (FLUSH)
//             redirect_valid - one-cycle replay strobe (REPLAY)
//             redirect_pc    - PC captured at the last accepted fault
//             trap           - unrecoverable fault, level
//             retry_count    - consecutive retries of the current instruction
//             fault_count    - accepted faults since reset, saturating
//             busy           - controller not idle
//
//  Revision : 1.0 - initial release
// ============================================================================
module fault_recovery_ctrl #(
  parameter int XLEN         = 32,
  parameter int MAX_RETRY    = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int FCNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fault_detected,
  input  logic              instr_valid,
  input  logic [XLEN-1:0]   fault_pc,
  input  logic              retire,
  input  logic              trap_ack,
  output logic              stall,
  output logic              flush,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              trap,
  output logic [2:0]        retry_count,
  output logic [FCNT_W-1:0] fault_count,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_REPLAY = 2'd2,
    ST_TRAP   = 2'd3
  } state_e;

  // The flush counter counts down to zero, so it is loaded with one less
  // than the number of flush cycles on entry to FLUSH.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [2:0] RETRY_MAX  = 3'(MAX_RETRY);

  state_e              state_q,     state_d;
  logic [3:0]          flush_cnt_q, flush_cnt_d;
  logic [2:0]          retry_q,     retry_d;
  logic [FCNT_W-1:0]   fault_cnt_q, fault_cnt_d;
  logic [XLEN-1:0]     pc_q,        pc_d;
  logic                stall_q,     stall_d;
  logic                flush_q,     flush_d;
  logic                redir_q,     redir_d;
  logic                trap_q,      trap_d;
  logic                busy_q,      busy_d;

  logic                fault_accept;

  assign fault_accept = fault_detected & instr_valid;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    retry_d     = retry_q;
    fault_cnt_d = fault_cnt_q;
    pc_d        = pc_q;

    case (state_q)
      ST_IDLE: begin
        if (fault_accept) begin
          // A fault in the same cycle as retire takes priority, so the
          // retry count is never cleared on this path.
          pc_d = fault_pc;
          if (fault_cnt_q != {FCNT_W{1'b1}}) begin
            fault_cnt_d = fault_cnt_q + FCNT_W'(1);
          end
          if (retry_q < RETRY_MAX) begin
            retry_d     = retry_q + 3'd1;
            flush_cnt_d = FLUSH_LOAD;
            state_d     = ST_FLUSH;
          end else begin
            state_d = ST_TRAP;
          end
        end else if (retire) begin
          retry_d = 3'd0;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == 4'd0) begin
          state_d = ST_REPLAY;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      ST_REPLAY: begin
        state_d = ST_IDLE;
      end
      ST_TRAP: begin
        if (trap_ack) begin
          retry_d = 3'd0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state and registered, so each one
    // lines up exactly with the state it belongs to.
    stall_d = (state_d == ST_FLUSH) || (state_d == ST_TRAP);
    flush_d = (state_d == ST_FLUSH);
    redir_d = (state_d == ST_REPLAY);
    trap_d  = (state_d == ST_TRAP);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= 4'd0;
      retry_q     <= 3'd0;
      fault_cnt_q <= '0;
      pc_q        <= '0;
      stall_q     <= 1'b0;
      flush_q     <= 1'b0;
      redir_q     <= 1'b0;
      trap_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      retry_q     <= retry_d;
      fault_cnt_q <= fault_cnt_d;
      pc_q        <= pc_d;
      stall_q     <= stall_d;
      flush_q     <= flush_d;
      redir_q     <= redir_d;
      trap_q      <= trap_d;
      busy_q      <= busy_d;
    end
  end

  assign stall          = stall_q;
  assign flush          = flush_q;
  assign redirect_valid = redir_q;
  assign redirect_pc    = pc_q;
  assign trap           = trap_q;
  assign retry_count    = retry_q;
  assign fault_count    = fault_cnt_q;
  assign busy           = busy_q;

endmodule
`default_nettype wire
